// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: multi-request prefetch with a PC-tagged
// instruction queue, credit-based issue and redirect flush.
module if_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
  localparam int             AW       = $clog2(DEPTH),
  localparam int             CW       = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [CW-1:0]   occupancy
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic [CW:0]     inflight;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            dropping;
  logic [XLEN-1:0] redir_al;

  // credit covers both buffered and in-flight words so a push never overflows
  assign inflight = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !reset && !redirect_valid
                       && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign dropping = drop_q != '0;
  assign push     = imem_resp_valid && !dropping && !redirect_valid;
  assign id_valid = count_q != '0;
  assign pop      = id_valid && id_ready && !redirect_valid;
  assign redir_al = redirect_pc & ~XLEN'(3);

  assign id_inst   = inst_q[rd_ptr_q];
  assign id_pc     = pc_q[rd_ptr_q];
  assign id_pc4    = id_pc + XLEN'(4);
  assign occupancy = count_q;

  always_comb begin
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    fetch_pc_d = req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    resp_pc_d  = push ? resp_pc_q + XLEN'(4) : resp_pc_q;
    if (imem_resp_valid && dropping) begin
      drop_d = drop_q - CW'(1);
    end
    if (redirect_valid) begin
      drop_d     = outst_q - CW'(imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fetch_pc_d = redir_al;
      resp_pc_d  = redir_al;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= imem_resp_data;
      pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed and randomised checks of if_prefetch_unit against a bench-side
// in-order memory model and a golden PC sequence.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [2:0]  occupancy;

  if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  bit resp_hold = 1'b0;
  int first_idv;

  logic [31:0] pend_addr[$];
  int          pend_due[$];

  logic [31:0] fire_addr[$];
  int          fire_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  logic [31:0] pop_pc4[$];

  logic        s_fire, s_resp, s_pop, s_idv, s_rqv;
  logic [31:0] s_addr;
  logic [2:0]  s_occ;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic clear_logs();
    fire_addr.delete(); fire_cyc.delete();
    pop_pc.delete(); pop_inst.delete(); pop_pc4.delete();
    first_idv = -1;
  endtask

  // one clock cycle: memory drives its response, outputs are sampled
  // mid-cycle, then the memory model commits after the edge
  task automatic tick();
    if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc && !resp_hold) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    s_fire = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_resp = imem_resp_valid;
    s_pop  = id_valid && id_ready && !redirect_valid && !reset;
    s_idv  = id_valid;
    s_rqv  = imem_req_valid;
    s_occ  = occupancy;
    if (s_fire) begin fire_addr.push_back(s_addr); fire_cyc.push_back(cyc); end
    if (s_pop) begin
      pop_pc.push_back(id_pc); pop_inst.push_back(id_inst); pop_pc4.push_back(id_pc4);
    end
    if (s_idv && first_idv < 0) first_idv = cyc;
    @(posedge clk); #1;
    if (reset) begin
      pend_addr.delete(); pend_due.delete();
    end else begin
      if (s_resp) begin void'(pend_addr.pop_front()); void'(pend_due.pop_front()); end
      if (s_fire) begin pend_addr.push_back(s_addr); pend_due.push_back(cyc + lat); end
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; resp_hold = 1'b0;
    imem_req_ready = 1'b1; id_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b1;
    tick(); tick();
    total++; if (s_rqv !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", s_rqv); end
    total++; if (s_idv !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b want=0", s_idv); end
    total++; if (s_occ !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", s_occ); end
  endtask

  task automatic test_stream();
    lat = 1; do_reset();
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fire_addr.size() <= i || fire_addr[i] !== 32'(4*i)) begin
        bad++; $display("FAIL stream_addr%0d got=%h want=%h", i,
          (fire_addr.size() > i) ? fire_addr[i] : 32'hx, 32'(4*i));
      end
    end
    total++;
    if (fire_cyc.size() == 0 || first_idv - fire_cyc[0] != 2) begin
      bad++; $display("FAIL stream_latency got=%0d want=2",
        (fire_cyc.size() > 0) ? first_idv - fire_cyc[0] : -1);
    end
    total++; if (pop_pc.size() != 10) begin bad++; $display("FAIL stream_pops got=%0d want=10", pop_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pop_pc.size() <= i || pop_pc[i] !== 32'(4*i) || pop_inst[i] !== inst_of(32'(4*i))
          || pop_pc4[i] !== 32'(4*i+4)) begin
        bad++; $display("FAIL stream_pop%0d got=%h want pc=%h", i,
          (pop_pc.size() > i) ? pop_pc[i] : 32'hx, 32'(4*i));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++; if (fire_addr.size() != 4) begin bad++; $display("FAIL bp_requests got=%0d want=4", fire_addr.size()); end
    total++; if (s_occ !== 3'd4) begin bad++; $display("FAIL bp_occupancy got=%0d want=4", s_occ); end
    total++; if (s_rqv !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b want=0", s_rqv); end
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pop_pc.size() <= i || pop_pc[i] !== 32'(4*i) || pop_inst[i] !== inst_of(32'(4*i))) begin
        bad++; $display("FAIL bp_pop%0d got=%h want=%h", i,
          (pop_pc.size() > i) ? pop_pc[i] : 32'hx, 32'(4*i));
      end
    end
  endtask

  task automatic test_redirect_stale();
    lat = 3; do_reset();
    tick(); tick(); tick();
    total++; if (pend_addr.size() != 3) begin bad++; $display("FAIL stale_inflight got=%0d want=3", pend_addr.size()); end
    resp_hold = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    total++; if (s_rqv !== 1'b0) begin bad++; $display("FAIL stale_req_in_redirect got=%b want=0", s_rqv); end
    resp_hold = 1'b0; redirect_valid = 1'b0;
    clear_logs();
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (fire_addr.size() == 0 || fire_addr[0] !== 32'h100) begin
      bad++; $display("FAIL stale_next_addr got=%h want=00000100",
        (fire_addr.size() > 0) ? fire_addr[0] : 32'hx);
    end
    total++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h100 || pop_inst[0] !== inst_of(32'h100)) begin
      bad++; $display("FAIL stale_first_pc got=%h want=00000100",
        (pop_pc.size() > 0) ? pop_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1; do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    total++; if (!(s_resp && s_idv)) begin bad++; $display("FAIL same_setup got=%b%b want=11", s_resp, s_idv); end
    total++; if (s_rqv !== 1'b0) begin bad++; $display("FAIL same_req_valid got=%b want=0", s_rqv); end
    redirect_valid = 1'b0;
    clear_logs();
    tick();
    total++; if (s_occ !== 3'd0 || s_idv !== 1'b0) begin bad++; $display("FAIL same_flush got=%0d want=0", s_occ); end
    total++;
    if (!s_fire || s_addr !== 32'h200) begin
      bad++; $display("FAIL same_align got=%h want=00000200", s_addr);
    end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h200 || pop_inst[0] !== inst_of(32'h200)) begin
      bad++; $display("FAIL same_first_pc got=%h want=00000200",
        (pop_pc.size() > 0) ? pop_pc[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    lat = 1; do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fire_addr.size() <= i || fire_addr[i] !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i,
          (fire_addr.size() > i) ? fire_addr[i] : 32'hx, exp_a[i]);
      end
    end
    total++;
    if (pop_pc.size() < 2 || pop_pc[1] !== 32'hFFFF_FFFC || pop_pc4[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_pc4 got=%h want=00000000",
        (pop_pc4.size() > 1) ? pop_pc4[1] : 32'hx);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        rv;
    int          npop;
    lat = 2; do_reset();
    exp_pc = 32'h0; npop = 0;
    for (int i = 0; i < 10000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      resp_hold      = ($urandom % 4) == 0;
      id_ready       = ($urandom % 3) != 0;
      rv             = ($urandom % 50) == 0;
      tgt            = $urandom;
      redirect_valid = rv; redirect_pc = tgt;
      clear_logs();
      tick();
      if (pop_pc.size() == 1) begin
        npop++;
        total++;
        if (pop_pc[0] !== exp_pc || pop_inst[0] !== inst_of(exp_pc)
            || pop_pc4[0] !== exp_pc + 32'd4) begin
          bad++; $display("FAIL rand_pc cyc=%0d got=%h/%h want=%h/%h", cyc,
            pop_pc[0], pop_inst[0], exp_pc, inst_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (rv) exp_pc = tgt & ~32'd3;
      total++; if (s_occ > 3'd4) begin bad++; $display("FAIL rand_occ got=%0d want<=4", s_occ); end
      total++; if (pend_addr.size() > 4) begin bad++; $display("FAIL rand_outstanding got=%0d want<=4", pend_addr.size()); end
    end
    redirect_valid = 1'b0;
    total++; if (npop < 1000) begin bad++; $display("FAIL rand_progress got=%0d want>=1000", npop); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
